// File: rtl/complex_counter_4bit_if.sv
// Control/data bundle for complex_counter_4bit: enable and mode in, count (and optional tc) out.
// COMPLEX_COUNTER_TC_EN adds the terminal-count flag to the bundle.
interface complex_counter_4bit_if;
    logic       enable;
    logic [3:0] mode;
    logic [3:0] count;
`ifdef COMPLEX_COUNTER_TC_EN
    logic       tc;

    modport master (output enable, output mode, input count, input tc);
    modport slave  (input enable, input mode, output count, output tc);
`else
    modport master (output enable, output mode, input count);
    modport slave  (input enable, input mode, output count);
`endif
endinterface

// File: rtl/complex_counter_4bit.sv
// 4-bit multi-sequence counter: mode selects one of twelve sequences, enable gates advancing.
// Optional registered terminal-count flag under COMPLEX_COUNTER_TC_EN.
module complex_counter_4bit #(
    parameter logic [3:0] RESET_VALUE = 4'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    complex_counter_4bit_if.slave bus
);

    localparam logic [3:0] MODE_BIN_UP   = 4'd0;
    localparam logic [3:0] MODE_BIN_DN   = 4'd1;
    localparam logic [3:0] MODE_GRAY_UP  = 4'd2;
    localparam logic [3:0] MODE_GRAY_DN  = 4'd3;
    localparam logic [3:0] MODE_BCD_UP   = 4'd4;
    localparam logic [3:0] MODE_BCD_DN   = 4'd5;
    localparam logic [3:0] MODE_EVEN_UP  = 4'd6;
    localparam logic [3:0] MODE_ODD_UP   = 4'd7;
    localparam logic [3:0] MODE_JOHNSON  = 4'd8;
    localparam logic [3:0] MODE_RING     = 4'd9;
    localparam logic [3:0] MODE_MOD12_UP = 4'd10;
    localparam logic [3:0] MODE_MOD12_DN = 4'd11;

    logic [3:0] count_r;
    logic [3:0] next_s;
    logic [3:0] count_d_s;

    function automatic logic [3:0] bin2gray(input logic [3:0] b);
        return b ^ {1'b0, b[3:1]};
    endfunction

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    function automatic logic is_johnson(input logic [3:0] c);
        logic ok;
        case (c)
            4'b0000, 4'b0001, 4'b0011, 4'b0111,
            4'b1111, 4'b1110, 4'b1100, 4'b1000: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic is_onehot(input logic [3:0] c);
        logic ok;
        case (c)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: ok = 1'b1;
            default:                            ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Next value for the selected sequence; illegal states fall back to the mode's start value.
    always_comb begin
        next_s = count_r;
        case (bus.mode)
            MODE_BIN_UP:  next_s = count_r + 4'd1;
            MODE_BIN_DN:  next_s = count_r - 4'd1;
            MODE_GRAY_UP: next_s = bin2gray(gray2bin(count_r) + 4'd1);
            MODE_GRAY_DN: next_s = bin2gray(gray2bin(count_r) - 4'd1);
            MODE_BCD_UP: begin
                if (count_r >= 4'd9) next_s = 4'd0;
                else                 next_s = count_r + 4'd1;
            end
            MODE_BCD_DN: begin
                if ((count_r > 4'd9) || (count_r == 4'd0)) next_s = 4'd9;
                else                                       next_s = count_r - 4'd1;
            end
            // Even/odd wrap falls out of the 4-bit add (14+2 -> 0, 15+2 -> 1).
            MODE_EVEN_UP: begin
                if (count_r[0]) next_s = 4'd0;
                else            next_s = count_r + 4'd2;
            end
            MODE_ODD_UP: begin
                if (count_r[0]) next_s = count_r + 4'd2;
                else            next_s = 4'd1;
            end
            MODE_JOHNSON: begin
                if (is_johnson(count_r)) next_s = {count_r[2:0], ~count_r[3]};
                else                     next_s = 4'b0000;
            end
            MODE_RING: begin
                if (is_onehot(count_r)) next_s = {count_r[2:0], count_r[3]};
                else                    next_s = 4'b0001;
            end
            MODE_MOD12_UP: begin
                if (count_r >= 4'd11) next_s = 4'd0;
                else                  next_s = count_r + 4'd1;
            end
            MODE_MOD12_DN: begin
                if ((count_r > 4'd11) || (count_r == 4'd0)) next_s = 4'd11;
                else                                        next_s = count_r - 4'd1;
            end
            default: next_s = count_r;
        endcase
    end

    // Enable gates the step; reserved modes already hold through next_s.
    always_comb begin
        if (bus.enable == 1'b1) count_d_s = next_s;
        else                    count_d_s = count_r;
    end

    // Counter register with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) count_r <= RESET_VALUE;
        else     count_r <= count_d_s;
    end

    assign bus.count = count_r;

`ifdef COMPLEX_COUNTER_TC_EN
    logic tc_r;

    function automatic logic is_last(input logic [3:0] c, input logic [3:0] m);
        logic hit;
        case (m)
            MODE_BIN_UP:   hit = (c == 4'd15);
            MODE_BIN_DN:   hit = (c == 4'd0);
            MODE_GRAY_UP:  hit = (c == 4'b1000);
            MODE_GRAY_DN:  hit = (c == 4'b0000);
            MODE_BCD_UP:   hit = (c == 4'd9);
            MODE_BCD_DN:   hit = (c == 4'd0);
            MODE_EVEN_UP:  hit = (c == 4'd14);
            MODE_ODD_UP:   hit = (c == 4'd15);
            MODE_JOHNSON:  hit = (c == 4'b1000);
            MODE_RING:     hit = (c == 4'b1000);
            MODE_MOD12_UP: hit = (c == 4'd11);
            MODE_MOD12_DN: hit = (c == 4'd0);
            default:       hit = 1'b0;
        endcase
        return hit;
    endfunction

    // Flag follows the value the counter takes on this edge under the mode sampled on this edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tc_r <= 1'b0;
        else     tc_r <= is_last(count_d_s, bus.mode);
    end

    assign bus.tc = tc_r;
`endif

endmodule

// File: tb/tb_complex_counter_4bit.sv
// Scoreboard bench for complex_counter_4bit: sequence-table reference model, directed then random stimulus.
module tb_complex_counter_4bit;

    typedef struct {
        logic [3:0] cnt;
        logic       tc;
        int         id;
    } exp_t;

    logic clk;
    logic rst;
    complex_counter_4bit_if bus ();

    complex_counter_4bit #(.RESET_VALUE(4'd0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         total;
    int         bad;
    int         step_id;
    exp_t       exp_q[$];
    logic [3:0] seq [12][16];
    int         seq_len [12];
    logic [3:0] model_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic build_tables();
        logic [3:0] jv [8];
        logic [3:0] rv [4];
        jv = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
        rv = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int i = 0; i < 16; i++) begin
            seq[0][i] = 4'(i);
            seq[1][i] = 4'(15 - i);
            seq[2][i] = 4'(i ^ (i >> 1));
            seq[3][i] = 4'((15 - i) ^ ((15 - i) >> 1));
        end
        for (int i = 0; i < 10; i++) begin
            seq[4][i] = 4'(i);
            seq[5][i] = 4'(9 - i);
        end
        for (int i = 0; i < 8; i++) begin
            seq[6][i] = 4'(2 * i);
            seq[7][i] = 4'(2 * i + 1);
            seq[8][i] = jv[i];
        end
        for (int i = 0; i < 4; i++) seq[9][i] = rv[i];
        for (int i = 0; i < 12; i++) begin
            seq[10][i] = 4'(i);
            seq[11][i] = 4'(11 - i);
        end
        seq_len = '{16, 16, 16, 16, 10, 10, 8, 8, 8, 4, 12, 12};
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] c, input int m);
        if (m >= 12) return c;
        for (int i = 0; i < seq_len[m]; i++)
            if (seq[m][i] == c) return seq[m][(i + 1) % seq_len[m]];
        return seq[m][0];
    endfunction

    function automatic logic model_last(input logic [3:0] c, input int m);
        if (m >= 12) return 1'b0;
        return (c == seq[m][seq_len[m] - 1]);
    endfunction

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b, expected %b", name, act, req);
        end
    endtask

    task automatic step(input logic en, input int m);
        exp_t e;
        @(negedge clk);
        bus.enable = en;
        bus.mode   = 4'(m);
        if (en) model_cnt = model_next(model_cnt, m);
        e.cnt = model_cnt;
        e.tc  = model_last(model_cnt, m);
        e.id  = step_id++;
        exp_q.push_back(e);
    endtask

    // Asynchronous reset asserted and released away from clock edges.
    task automatic reset_pulse(input string tag);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_async"}, bus.count, 4'd0);
        #18;
        check({tag, "_held"}, bus.count, 4'd0);
        #1;
        rst = 1'b0;
        model_cnt = 4'd0;
    endtask

    // Monitor: pops one expectation after every edge that the stimulus has scheduled one for.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (bus.count !== e.cnt) begin
                    bad++;
                    $display("FAIL count step %0d: got %b, expected %b", e.id, bus.count, e.cnt);
                end
`ifdef COMPLEX_COUNTER_TC_EN
                total++;
                if (bus.tc !== e.tc) begin
                    bad++;
                    $display("FAIL tc step %0d: got %b, expected %b", e.id, bus.tc, e.tc);
                end
`endif
            end
        end
    end

    initial begin
        int m;
        int run;
        total     = 0;
        bad       = 0;
        step_id   = 0;
        model_cnt = 4'd0;
        build_tables();
        rst        = 1'b1;
        bus.enable = 1'b0;
        bus.mode   = 4'd0;
        #8;
        check("reset_value", bus.count, 4'd0);
`ifdef COMPLEX_COUNTER_TC_EN
        total++;
        if (bus.tc !== 1'b0) begin
            bad++;
            $display("FAIL reset_tc: got %b, expected 0", bus.tc);
        end
`endif
        #2;
        rst = 1'b0;

        for (int i = 0; i < 9; i++) step(1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'b1, 9);
        reset_pulse("rst_a");
        for (int i = 0; i < 10; i++) step(1'b1, 4);
        for (int i = 0; i < 12; i++) step(1'b1, 0);
        step(1'b1, 4);
        for (int i = 0; i < 8; i++) step(1'b1, 8);
        for (int i = 0; i < 16; i++) step(1'b1, 2);
        reset_pulse("rst_b");
        for (int i = 0; i < 7; i++) step(1'b1, 0);
        reset_pulse("rst_mid");
        step(1'b1, 0);
        for (int i = 0; i < 14; i++) step(1'b1, 10);
        for (int i = 0; i < 4; i++) step(1'b1, 13);
        for (int i = 0; i < 8; i++) step(1'b1, 11);
        step(1'b1, 5);
        step(1'b1, 7);

        for (int r = 0; r < 80; r++) begin
            m   = int'($urandom_range(0, 15));
            run = int'($urandom_range(1, 8));
            for (int k = 0; k < run; k++) step($urandom_range(0, 3) != 0, m);
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
